wb_pipe: RTL and testbench
==========================

WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width of every source and result.
REQ-002 SHALL have parameter NSRC, default 4 (minimum 2), the number of selectable result sources.
REQ-003 SHALL have parameter RADDR_W, default 4, the destination register address width.
REQ-004 SHALL have parameter SEL_W, default $clog2(NSRC), the selector width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 in_valid  in  1  upstream presents a result.
REQ-008 in_ready  out  1  block can accept a result this cycle.
REQ-009 in_sel  in  SEL_W  selects the source; 0 = ALU result, 1 = memory read data, others are user sources.
REQ-010 in_data  in  NSRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-011 in_rd  in  RADDR_W  destination register address.
REQ-012 in_we  in  1  result requests a register write.
REQ-013 flush  in  1  discard all buffered results.
REQ-014 out_valid  out  1  head result is present.
REQ-015 out_ready  in  1  register file accepts the head result this cycle.
REQ-016 out_data  out  WIDTH  selected data of the head result.
REQ-017 out_rd  out  RADDR_W  destination address of the head result.
REQ-018 wb_we  out  1  register-file write strobe.
REQ-019 commit_cnt  out  32  number of writes committed.

Function
REQ-020 SHALL capture a result on the rising edge when in_valid && in_ready.
REQ-021 SHALL select the captured data at capture time: in_data slice in_sel; if in_sel >= NSRC, SHALL store zero.
REQ-022 SHALL force the stored write-enable to 0 when in_rd == 0.
REQ-023 SHALL hold results in a 2-entry FIFO: head register plus skid register. Occupancy states are EMPTY, ONE and TWO.
REQ-024 SHALL set in_ready = (state != TWO), as a combinational function of state only.
REQ-025 SHALL drive out_valid = (state != EMPTY); out_data and out_rd come from the head register.
REQ-026 SHALL drive wb_we = out_valid && out_ready && head_we, combinationally.
REQ-027 SHALL give 1-cycle latency: a result captured at edge N appears on the outputs after edge N when the block was EMPTY or ONE-with-pop.
REQ-028 SHALL apply these state transitions on push (p) and pop (q = out_valid && out_ready):
- EMPTY: p -> ONE.
- ONE: p && !q -> TWO; !p && q -> EMPTY; otherwise stay in ONE, with the head replaced on p && q.
- TWO: q -> ONE, the skid moves to the head. A push is impossible because in_ready = 0.
REQ-029 SHALL preserve order: the skid entry is always younger than the head entry.
REQ-030 SHALL treat flush as highest priority: on that edge state -> EMPTY, the push and pop are discarded, and commit_cnt is not incremented.
REQ-031 Flush SHALL NOT gate wb_we combinationally in the flush cycle; the upstream deasserts out_ready during a flush.
REQ-032 SHALL increment commit_cnt by 1 on each edge where wb_we = 1, wrapping from 0xFFFFFFFF to 0.
REQ-033 SHALL keep the data outputs stable while out_valid && !out_ready.

Reset
REQ-034 On rst, SHALL asynchronously set state = EMPTY, out_valid = 0, wb_we = 0, in_ready = 1, out_data = 0, out_rd = 0 and commit_cnt = 0.
REQ-035 SHALL discard any in-flight entries on a reset asserted mid-operation; the first edge after release behaves as from EMPTY.

Structure
REQ-036 SHALL place the occupancy state enum (EMPTY/ONE/TWO) and the source-index constants (SRC_ALU = 0, SRC_MEM = 1) in the shared package wb_pkg.
REQ-037 SHALL instantiate one sub-module, result_mux (parameters WIDTH and NSRC), implementing the combinational source select of REQ-021.
REQ-038 SHALL keep the FIFO and the counter in wb_pipe.

Verification
REQ-039 Source select: WIDTH = 32, NSRC = 4, sources {0x00001122, 0x00AABBCC, 0x00112222, 0x00111111}; sel = 0..3 with rd = 5, we = 1, out_ready = 1 -> out_data 0x00001122, 0x00AABBCC, 0x00112222, 0x00111111 on consecutive cycles, and commit_cnt = 4.
REQ-040 Backpressure: out_ready = 0 with 3 pushes -> the first two accepted, in_ready = 0 on the third; after out_ready = 1, results drain in order with no loss.
REQ-041 Zero register: push rd = 0, we = 1, data 0xDEADBEEF -> out_valid = 1, wb_we = 0, commit_cnt unchanged.
REQ-042 Flush in TWO: flush = 1 with out_ready = 0 -> next cycle out_valid = 0, in_ready = 1, commit_cnt unchanged.
REQ-043 Counter wrap: preload via 2^32-1 commits (or force) and then one commit -> commit_cnt = 0.
REQ-044 Async reset mid-stream: assert rst between edges while in state TWO -> out_valid = 0 and commit_cnt = 0 immediately, without a clock edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back result pipeline.
package wb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_MEM = 1;
    localparam int unsigned CNT_W   = 32;

endpackage

// File: rtl/result_mux.sv
// Combinational result-source select; out-of-range selectors yield zero.
module result_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 4,
    parameter int unsigned SEL_W = $clog2(NSRC)
) (
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [NSRC*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]      data_o
);

    // Compare at 32 bits so selectors beyond NSRC never alias a real source.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (32'(sel_i) == 32'(k)) begin
                data_o = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/wb_pipe.sv
// Write-back stage: source select, 2-entry head/skid FIFO and commit counter.
module wb_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NSRC    = 4,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned SEL_W   = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [NSRC*WIDTH-1:0] in_data,
    input  logic [RADDR_W-1:0]    in_rd,
    input  logic                  in_we,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [RADDR_W-1:0]    out_rd,
    output logic                  wb_we,
    output logic [31:0]           commit_cnt
);
    import wb_pkg::*;

    occ_e               state_q, state_d;
    logic [WIDTH-1:0]   head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic [RADDR_W-1:0] head_rd_q, head_rd_d, skid_rd_q, skid_rd_d;
    logic               head_we_q, head_we_d, skid_we_q, skid_we_d;
    logic [CNT_W-1:0]   commit_q, commit_d;

    logic [WIDTH-1:0]   sel_data;
    logic               new_we;
    logic               push;
    logic               pop;

    result_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SEL_W (SEL_W)
    ) u_result_mux (
        .sel_i  (in_sel),
        .data_i (in_data),
        .data_o (sel_data)
    );

    // Writes to register 0 are dropped at capture time.
    assign new_we = in_we && (in_rd != '0);

    assign in_ready   = (state_q != TWO);
    assign out_valid  = (state_q != EMPTY);
    assign out_data   = head_data_q;
    assign out_rd     = head_rd_q;
    assign wb_we      = out_valid && out_ready && head_we_q;
    assign commit_cnt = commit_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_rd_d   = head_rd_q;
        head_we_d   = head_we_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        skid_we_d   = skid_we_q;
        commit_d    = commit_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            if (wb_we) begin
                commit_d = commit_q + CNT_W'(1);
            end
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_data_d = sel_data;
                        head_rd_d   = in_rd;
                        head_we_d   = new_we;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_data_d = sel_data;
                        head_rd_d   = in_rd;
                        head_we_d   = new_we;
                    end else if (push) begin
                        skid_data_d = sel_data;
                        skid_rd_d   = in_rd;
                        skid_we_d   = new_we;
                        state_d     = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // Skid is always the younger entry, so it becomes the head.
                    if (pop) begin
                        head_data_d = skid_data_q;
                        head_rd_d   = skid_rd_q;
                        head_we_d   = skid_we_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_rd_q   <= '0;
            head_we_q   <= 1'b0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            skid_we_q   <= 1'b0;
            commit_q    <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_rd_q   <= head_rd_d;
            head_we_q   <= head_we_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            skid_we_q   <= skid_we_d;
            commit_q    <= commit_d;
        end
    end

endmodule

// File: tb/tb_wb_pipe.sv
// Directed bench for wb_pipe: vector table for source select plus corner sequences.
module tb_wb_pipe;
    import wb_pkg::*;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NSRC    = 4;
    localparam int unsigned RADDR_W = 4;
    localparam int unsigned SEL_W   = 2;
    localparam logic [NSRC*WIDTH-1:0] SRCS =
        {32'h0011_1111, 32'h0011_2222, 32'h00AA_BBCC, 32'h0000_1122};

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_W-1:0]      in_sel;
    logic [NSRC*WIDTH-1:0] in_data;
    logic [RADDR_W-1:0]    in_rd;
    logic                  in_we;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [RADDR_W-1:0]    out_rd;
    logic                  wb_we;
    logic [31:0]           commit_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [SEL_W-1:0]   sel;
        logic [RADDR_W-1:0] rd;
        logic               we;
        logic [WIDTH-1:0]   exp_data;
        logic               exp_wb_we;
        logic [31:0]        exp_cnt;
    } vec_t;

    vec_t vecs[6];

    wb_pipe #(
        .WIDTH   (WIDTH),
        .NSRC    (NSRC),
        .RADDR_W (RADDR_W),
        .SEL_W   (SEL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .wb_we      (wb_we),
        .commit_cnt (commit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int sel, input int rd, input logic we);
        in_valid = v;
        in_sel   = SEL_W'(sel);
        in_rd    = RADDR_W'(rd);
        in_we    = we;
    endtask

    initial begin
        logic [NSRC*WIDTH-1:0] data_v;

        vecs[0] = '{sel: 2'd0, rd: 4'd5, we: 1'b1, exp_data: 32'h0000_1122, exp_wb_we: 1'b1, exp_cnt: 32'd0};
        vecs[1] = '{sel: 2'd1, rd: 4'd5, we: 1'b1, exp_data: 32'h00AA_BBCC, exp_wb_we: 1'b1, exp_cnt: 32'd1};
        vecs[2] = '{sel: 2'd2, rd: 4'd5, we: 1'b1, exp_data: 32'h0011_2222, exp_wb_we: 1'b1, exp_cnt: 32'd2};
        vecs[3] = '{sel: 2'd3, rd: 4'd5, we: 1'b1, exp_data: 32'h0011_1111, exp_wb_we: 1'b1, exp_cnt: 32'd3};
        vecs[4] = '{sel: 2'd0, rd: 4'd0, we: 1'b1, exp_data: 32'h0000_1122, exp_wb_we: 1'b0, exp_cnt: 32'd4};
        vecs[5] = '{sel: 2'd1, rd: 4'd9, we: 1'b0, exp_data: 32'h00AA_BBCC, exp_wb_we: 1'b0, exp_cnt: 32'd4};

        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = SRCS;
        drive(1'b0, 0, 0, 1'b0);

        // Reset state, observed before the first clock edge.
        #2 rst = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wb_we", 64'(wb_we), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_commit_cnt", 64'(commit_cnt), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Source select table with streaming push+pop.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, int'(vecs[i].sel), int'(vecs[i].rd), vecs[i].we);
            tick();
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_out_rd", i), 64'(out_rd), 64'(vecs[i].rd));
            check($sformatf("vec%0d_wb_we", i), 64'(wb_we), 64'(vecs[i].exp_wb_we));
            check($sformatf("vec%0d_commit_cnt", i), 64'(commit_cnt), 64'(vecs[i].exp_cnt));
        end
        drive(1'b0, 0, 0, 1'b0);
        tick();
        check("table_drain_valid", 64'(out_valid), 64'd0);
        check("table_commit_cnt", 64'(commit_cnt), 64'd4);

        // Zero register destination.
        data_v        = SRCS;
        data_v[31:0]  = 32'hDEAD_BEEF;
        in_data       = data_v;
        drive(1'b1, int'(SRC_ALU), 0, 1'b1);
        tick();
        drive(1'b0, 0, 0, 1'b0);
        #1;
        check("zr_out_valid", 64'(out_valid), 64'd1);
        check("zr_out_data", 64'(out_data), 64'hDEAD_BEEF);
        check("zr_wb_we", 64'(wb_we), 64'd0);
        tick();
        check("zr_commit_cnt", 64'(commit_cnt), 64'd4);
        in_data = SRCS;

        // Backpressure: third push refused, then in-order drain.
        out_ready = 1'b0;
        drive(1'b1, int'(SRC_ALU), 1, 1'b1);
        tick();
        check("bp_first_ready", 64'(in_ready), 64'd1);
        drive(1'b1, int'(SRC_MEM), 2, 1'b1);
        tick();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 2, 3, 1'b1);
        tick();
        check("bp_third_ready", 64'(in_ready), 64'd0);
        check("bp_hold_data", 64'(out_data), 64'h0000_1122);
        check("bp_hold_rd", 64'(out_rd), 64'd1);
        out_ready = 1'b1;
        #1;
        check("bp_wb_we", 64'(wb_we), 64'd1);
        tick();
        check("bp_drain1_data", 64'(out_data), 64'h00AA_BBCC);
        check("bp_drain1_rd", 64'(out_rd), 64'd2);
        check("bp_drain1_ready", 64'(in_ready), 64'd1);
        check("bp_drain1_cnt", 64'(commit_cnt), 64'd5);
        tick();
        drive(1'b0, 0, 0, 1'b0);
        check("bp_drain2_data", 64'(out_data), 64'h0011_2222);
        check("bp_drain2_rd", 64'(out_rd), 64'd3);
        check("bp_drain2_cnt", 64'(commit_cnt), 64'd6);
        tick();
        check("bp_empty_valid", 64'(out_valid), 64'd0);
        check("bp_final_cnt", 64'(commit_cnt), 64'd7);

        // Flush while full and stalled.
        out_ready = 1'b0;
        drive(1'b1, 3, 4, 1'b1);
        tick();
        drive(1'b1, 0, 6, 1'b1);
        tick();
        drive(1'b0, 0, 0, 1'b0);
        check("fl_full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        check("fl_commit_cnt", 64'(commit_cnt), 64'd7);

        // Flush wins over a simultaneous push and pop.
        drive(1'b1, 1, 8, 1'b1);
        tick();
        drive(1'b1, 2, 9, 1'b1);
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check("flpp_wb_we_ungated", 64'(wb_we), 64'd1);
        tick();
        flush = 1'b0;
        drive(1'b0, 0, 0, 1'b0);
        check("flpp_out_valid", 64'(out_valid), 64'd0);
        check("flpp_commit_cnt", 64'(commit_cnt), 64'd7);
        tick();
        check("flpp_push_dropped", 64'(out_valid), 64'd0);

        // Counter wrap from all-ones.
        force dut.commit_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_q;
        check("wrap_preload", 64'(commit_cnt), 64'hFFFF_FFFF);
        drive(1'b1, 0, 5, 1'b1);
        tick();
        drive(1'b0, 0, 0, 1'b0);
        tick();
        check("wrap_commit_cnt", 64'(commit_cnt), 64'd0);

        // Async reset while full, then restart from empty.
        drive(1'b1, 1, 2, 1'b1);
        tick();
        drive(1'b0, 0, 0, 1'b0);
        tick();
        check("ar_pre_cnt", 64'(commit_cnt), 64'd1);
        out_ready = 1'b0;
        drive(1'b1, 2, 3, 1'b1);
        tick();
        drive(1'b1, 3, 4, 1'b1);
        tick();
        drive(1'b0, 0, 0, 1'b0);
        check("ar_full_ready", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_commit_cnt", 64'(commit_cnt), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_out_data", 64'(out_data), 64'd0);
        check("ar_out_rd", 64'(out_rd), 64'd0);
        #1 rst = 1'b0;
        tick();
        check("ar_post_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 1, 7, 1'b1);
        tick();
        drive(1'b0, 0, 0, 1'b0);
        check("ar_restart_valid", 64'(out_valid), 64'd1);
        check("ar_restart_data", 64'(out_data), 64'h00AA_BBCC);
        check("ar_restart_rd", 64'(out_rd), 64'd7);
        tick();
        check("ar_restart_cnt", 64'(commit_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
